branch_predictor: RTL and testbench

Dynamic branch predictor and misprediction controller for the RISC-V core, sitting between fetch (prediction lookup) and the branch-condition stage (resolution). It holds a direct-mapped table of 2-bit saturating counters indexed by PC and updates it with resolved outcomes. It raises a registered flush pulse when a conditional branch resolves against its prediction, and it keeps saturating statistics counters.

---
 rtl/bp_pkg.sv | 39 +++
 rtl/branch_predictor_sat_counter2.sv | 24 ++
 rtl/branch_predictor.sv | 133 +++++++++++++
 tb/tb_branch_predictor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor.
//   br_type_e      : branch-type encoding shared with the branch comparator
//   ctr_e          : 2-bit saturating counter states
//   is_conditional : true for the six compare-based branch types
package bp_pkg;

  typedef enum logic [2:0] {
    BR_BEQ    = 3'b000,
    BR_BNE    = 3'b001,
    BR_ALWAYS = 3'b010,
    BR_NEVER  = 3'b011,
    BR_BLT    = 3'b100,
    BR_BGE    = 3'b101,
    BR_BLTU   = 3'b110,
    BR_BGEU   = 3'b111
  } br_type_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = WNT;

  // Unknown (X) encodings match no item and fall to the default,
  // so they are treated as non-conditional.
  function automatic logic is_conditional(input logic [2:0] br_type);
    logic res;
    res = 1'b0;
    case (br_type)
      BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU: res = 1'b1;
      default:                                          res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of one 2-bit saturating branch counter.
//   state_i : current counter state
//   taken_i : resolved branch outcome
//   next_o  : counter state after applying the outcome
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_e state_i,
  input  logic taken_i,
  output ctr_e next_o
);

  always_comb begin
    next_o = state_i;
    case (state_i)
      SNT:     next_o = taken_i ? WNT : SNT;
      WNT:     next_o = taken_i ? WT  : SNT;
      WT:      next_o = taken_i ? ST  : WNT;
      ST:      next_o = taken_i ? ST  : WT;
      default: next_o = CTR_RESET;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter branch predictor with mispredict flush and
// saturating statistics.
//   clk, rst                     : clock, async active-high reset
//   pred_valid, pred_pc          : prediction lookup from fetch
//   pred_taken, pred_ready       : registered prediction, 1 cycle later
//   upd_valid, upd_pc,
//   upd_br_type, upd_taken,
//   upd_pred_taken               : resolved branch from the condition stage
//   flush                        : one-cycle registered mispredict pulse
//   stat_branches,
//   stat_mispredicts             : saturating counts of conditional branches
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  input  logic [31:0]       pred_pc,
  output logic              pred_taken,
  output logic              pred_ready,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [2:0]        upd_br_type,
  input  logic              upd_taken,
  input  logic              upd_pred_taken,
  output logic              flush,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] upd_idx;

  ctr_e table_q [ENTRIES];
  ctr_e table_d [ENTRIES];

  ctr_e pred_ctr;
  ctr_e upd_cur;
  ctr_e upd_next;
  logic upd_cond;
  logic mispredict;

  logic              pred_taken_q, pred_taken_d;
  logic              pred_ready_q, pred_ready_d;
  logic              flush_q, flush_d;
  logic [STAT_W-1:0] stat_br_q, stat_br_d;
  logic [STAT_W-1:0] stat_mis_q, stat_mis_d;

  // PC bits outside the index are intentionally ignored (aliasing allowed).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                            upd_pc[31:IDX_W+2], upd_pc[1:0]};

  assign pred_idx   = pred_pc[IDX_W+1:2];
  assign upd_idx    = upd_pc[IDX_W+1:2];
  assign pred_ctr   = table_q[pred_idx];
  assign upd_cur    = table_q[upd_idx];
  assign upd_cond   = upd_valid && is_conditional(upd_br_type);
  assign mispredict = upd_cond && (upd_pred_taken != upd_taken);

  sat_counter2 u_ctr (
    .state_i (upd_cur),
    .taken_i (upd_taken),
    .next_o  (upd_next)
  );

  // Lookup reads table_q, so a same-cycle update to the same entry is not
  // visible until the following cycle (read-before-write).
  always_comb begin
    table_d = table_q;
    if (upd_cond) begin
      table_d[upd_idx] = upd_next;
    end
  end

  always_comb begin
    pred_ready_d = pred_valid;
    pred_taken_d = pred_taken_q;
    if (pred_valid) begin
      pred_taken_d = (pred_ctr == WT) || (pred_ctr == ST);
    end
  end

  always_comb begin
    flush_d    = mispredict;
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;
    if (upd_cond && (stat_br_q != '1)) begin
      stat_br_d = stat_br_q + STAT_W'(1);
    end
    if (mispredict && (stat_mis_q != '1)) begin
      stat_mis_d = stat_mis_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        table_q[i] <= CTR_RESET;
      end
    end else begin
      table_q <= table_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_taken_q <= 1'b0;
      pred_ready_q <= 1'b0;
      flush_q      <= 1'b0;
      stat_br_q    <= '0;
      stat_mis_q   <= '0;
    end else begin
      pred_taken_q <= pred_taken_d;
      pred_ready_q <= pred_ready_d;
      flush_q      <= flush_d;
      stat_br_q    <= stat_br_d;
      stat_mis_q   <= stat_mis_d;
    end
  end

  assign pred_taken       = pred_taken_q;
  assign pred_ready       = pred_ready_q;
  assign flush            = flush_q;
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int STAT_W  = 8;
  localparam int SMAX    = (1 << STAT_W) - 1;

  logic              clk;
  logic              rst;
  logic              pred_valid;
  logic [31:0]       pred_pc;
  logic              pred_taken;
  logic              pred_ready;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic [2:0]        upd_br_type;
  logic              upd_taken;
  logic              upd_pred_taken;
  logic              flush;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  branch_predictor #(.ENTRIES(ENTRIES), .STAT_W(STAT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .pred_ready       (pred_ready),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_br_type      (upd_br_type),
    .upd_taken        (upd_taken),
    .upd_pred_taken   (upd_pred_taken),
    .flush            (flush),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        pv;
    logic [31:0] ppc;
    logic        uv;
    logic [31:0] upc;
    logic [2:0]  ubt;
    logic        ut;
    logic        upt;
    int          e_tk;
    int          e_rdy;
    int          e_fl;
    int          e_br;
    int          e_mis;
  } vec_t;

  vec_t vecs[$];

  // behavioural model state
  int mctr[ENTRIES];
  int m_tk, m_br, m_mis;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] ppc, input logic uv,
                       input logic [31:0] upc, input logic [2:0] ubt,
                       input logic ut, input logic upt);
    pred_valid     = pv;
    pred_pc        = ppc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_br_type    = ubt;
    upd_taken      = ut;
    upd_pred_taken = upt;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(0, 0, 0, 0, 3'b010, 0, 0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < ENTRIES; i++) mctr[i] = 1;
    m_tk = 0; m_br = 0; m_mis = 0;
  endtask

  function automatic vec_t mk(input logic pv, input logic [31:0] ppc, input logic uv,
                              input logic [31:0] upc, input logic [2:0] ubt,
                              input logic ut, input logic upt, input int tk,
                              input int rdy, input int fl, input int br, input int mis);
    vec_t v;
    v.pv = pv; v.ppc = ppc; v.uv = uv; v.upc = upc; v.ubt = ubt;
    v.ut = ut; v.upt = upt; v.e_tk = tk; v.e_rdy = rdy; v.e_fl = fl;
    v.e_br = br; v.e_mis = mis;
    return v;
  endfunction

  // one randomized cycle checked against the counter-array model
  task automatic rand_cycle;
    logic        pv, uv, ut, upt;
    logic [31:0] ppc, upc;
    logic [2:0]  ubt;
    int pidx, uidx, e_rdy, e_fl;
    bit cond;
    pv  = 1'($urandom_range(0, 1));
    uv  = ($urandom_range(0, 3) != 0);
    ppc = $urandom;
    upc = ($urandom_range(0, 3) == 0) ? ppc : $urandom;
    ubt = 3'($urandom_range(0, 7));
    ut  = 1'($urandom_range(0, 1));
    pidx = int'((ppc >> 2) % ENTRIES);
    uidx = int'((upc >> 2) % ENTRIES);
    upt = ($urandom_range(0, 3) != 0) ? (mctr[uidx] >= 2) : 1'($urandom_range(0, 1));
    drive(pv, ppc, uv, upc, ubt, ut, upt);
    e_rdy = pv;
    if (pv) m_tk = (mctr[pidx] >= 2) ? 1 : 0;
    cond = uv && !(ubt == 3'd2 || ubt == 3'd3);
    e_fl = (cond && (ut != upt)) ? 1 : 0;
    if (cond) begin
      if (m_br < SMAX) m_br++;
      if (e_fl == 1 && m_mis < SMAX) m_mis++;
      if (ut) mctr[uidx] = (mctr[uidx] + 1 > 3) ? 3 : mctr[uidx] + 1;
      else    mctr[uidx] = (mctr[uidx] - 1 < 0) ? 0 : mctr[uidx] - 1;
    end
    tick;
    chk("rnd_pred_ready", int'(pred_ready), e_rdy);
    chk("rnd_pred_taken", int'(pred_taken), m_tk);
    chk("rnd_flush", int'(flush), e_fl);
    chk("rnd_stat_branches", int'(stat_branches), m_br);
    chk("rnd_stat_mispredicts", int'(stat_mispredicts), m_mis);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 3'b010, 0, 0);

    //          pv  ppc        uv  upc        ubt     ut upt  tk rdy fl br mis
    vecs.push_back(mk(1, 32'h100, 0, 32'h0,   3'b000, 0, 0,   0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0,   1, 32'h100, 3'b000, 1, 0,   0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 32'h0,   1, 32'h100, 3'b000, 1, 1,   0, 0, 0, 2, 1));
    vecs.push_back(mk(0, 32'h0,   1, 32'h100, 3'b000, 1, 1,   0, 0, 0, 3, 1));
    vecs.push_back(mk(1, 32'h100, 0, 32'h0,   3'b000, 0, 0,   1, 1, 0, 3, 1));
    vecs.push_back(mk(1, 32'h140, 0, 32'h0,   3'b000, 0, 0,   1, 1, 0, 3, 1));
    vecs.push_back(mk(0, 32'h0,   1, 32'h104, 3'b100, 1, 0,   1, 0, 1, 4, 2));
    vecs.push_back(mk(1, 32'h144, 0, 32'h0,   3'b000, 0, 0,   1, 1, 0, 4, 2));
    vecs.push_back(mk(1, 32'h104, 1, 32'h104, 3'b101, 0, 1,   1, 1, 1, 5, 3));
    vecs.push_back(mk(1, 32'h104, 0, 32'h0,   3'b000, 0, 0,   0, 1, 0, 5, 3));
    vecs.push_back(mk(0, 32'h0,   1, 32'h108, 3'b010, 1, 0,   0, 0, 0, 5, 3));
    vecs.push_back(mk(0, 32'h0,   1, 32'h108, 3'b011, 1, 0,   0, 0, 0, 5, 3));
    vecs.push_back(mk(1, 32'h108, 0, 32'h0,   3'b000, 0, 0,   0, 1, 0, 5, 3));
    vecs.push_back(mk(0, 32'h0,   1, 32'h108, 3'b110, 1, 0,   0, 0, 1, 6, 4));
    vecs.push_back(mk(0, 32'h0,   1, 32'h108, 3'b111, 1, 0,   0, 0, 1, 7, 5));
    vecs.push_back(mk(0, 32'h0,   1, 32'h108, 3'b001, 0, 0,   0, 0, 0, 8, 5));
    vecs.push_back(mk(1, 32'h108, 0, 32'h0,   3'b000, 0, 0,   1, 1, 0, 8, 5));

    do_reset;
    chk("reset_pred_taken", int'(pred_taken), 0);
    chk("reset_pred_ready", int'(pred_ready), 0);
    chk("reset_flush", int'(flush), 0);
    chk("reset_stat_branches", int'(stat_branches), 0);
    chk("reset_stat_mispredicts", int'(stat_mispredicts), 0);

    foreach (vecs[k]) begin
      drive(vecs[k].pv, vecs[k].ppc, vecs[k].uv, vecs[k].upc, vecs[k].ubt,
            vecs[k].ut, vecs[k].upt);
      tick;
      chk($sformatf("vec%0d_pred_taken", k), int'(pred_taken), vecs[k].e_tk);
      chk($sformatf("vec%0d_pred_ready", k), int'(pred_ready), vecs[k].e_rdy);
      chk($sformatf("vec%0d_flush", k), int'(flush), vecs[k].e_fl);
      chk($sformatf("vec%0d_stat_branches", k), int'(stat_branches), vecs[k].e_br);
      chk($sformatf("vec%0d_stat_mispredicts", k), int'(stat_mispredicts), vecs[k].e_mis);
    end

    // saturation: 2^STAT_W+5 back-to-back mispredicts
    do_reset;
    for (int n = 0; n < SMAX + 6; n++) begin
      drive(1, 32'h100, 1, 32'h100, 3'b000, 1, 0);
      tick;
      chk("sat_flush_consecutive", int'(flush), 1);
    end
    chk("sat_stat_branches", int'(stat_branches), SMAX);
    chk("sat_stat_mispredicts", int'(stat_mispredicts), SMAX);
    chk("sat_pred_taken", int'(pred_taken), 1);

    // asynchronous reset mid-stream, between clock edges
    drive(1, 32'h100, 1, 32'h100, 3'b000, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flush", int'(flush), 0);
    chk("async_rst_pred_taken", int'(pred_taken), 0);
    chk("async_rst_pred_ready", int'(pred_ready), 0);
    chk("async_rst_stat_branches", int'(stat_branches), 0);
    chk("async_rst_stat_mispredicts", int'(stat_mispredicts), 0);
    #1 rst = 1'b0;
    drive(1, 32'h100, 0, 32'h0, 3'b000, 0, 0);
    tick;
    chk("post_rst_table_wnt", int'(pred_taken), 0);
    chk("post_rst_pred_ready", int'(pred_ready), 1);
    chk("post_rst_flush", int'(flush), 0);
    chk("post_rst_stat_branches", int'(stat_branches), 0);

    // randomized traffic against the model
    do_reset;
    for (int n = 0; n < 1500; n++) rand_cycle;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
